// File: rtl/seq_det_prog.sv
// Serial pattern detector with a run-time programmable PAT_LEN-bit pattern.
// Overlap mode is selectable, and a saturating detection counter is included.
module seq_det_prog #(
    parameter int                 PAT_LEN = 4,
    parameter logic [PAT_LEN-1:0] PATTERN = 4'b1011,
    parameter int                 CNT_W   = 8
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         seq_in,
    input  logic                         seq_valid,
    input  logic                         overlap_en,
    input  logic                         pat_load,
    input  logic [PAT_LEN-1:0]           pat_in,
    input  logic                         cnt_clr,
    output logic                         det_o,
    output logic [CNT_W-1:0]             det_count,
    output logic                         cnt_sat,
    output logic [$clog2(PAT_LEN+1)-1:0] fill
);
    localparam int               FW   = $clog2(PAT_LEN + 1);
    localparam logic [FW-1:0]    FULL = FW'(PAT_LEN);
    localparam logic [CNT_W-1:0] CMAX = '1;

    logic [PAT_LEN-1:0] pat_q, hist_q, hist_sh;
    logic [FW-1:0]      fill_q, fill_sh;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               det_q, sat_q, match;

    always_comb begin
        hist_sh = {hist_q[PAT_LEN-2:0], seq_in};
        fill_sh = (fill_q == FULL) ? FULL : fill_q + 1'b1;
        // A load in the same cycle discards the incoming bit, so it can never match.
        match   = seq_valid && !pat_load && (fill_sh == FULL) && (hist_sh == pat_q);
        cnt_d   = (match && (cnt_q != CMAX)) ? cnt_q + 1'b1 : cnt_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pat_q  <= PATTERN;
            hist_q <= '0;
            fill_q <= '0;
            det_q  <= 1'b0;
            cnt_q  <= '0;
            sat_q  <= 1'b0;
        end else begin
            det_q <= match;
            if (pat_load) begin
                pat_q  <= pat_in;
                hist_q <= '0;
                fill_q <= '0;
            end else if (seq_valid) begin
                if (match && !overlap_en) begin
                    hist_q <= '0;
                    fill_q <= '0;
                end else begin
                    hist_q <= hist_sh;
                    fill_q <= fill_sh;
                end
            end
            if (cnt_clr) begin
                cnt_q <= '0;
                sat_q <= 1'b0;
            end else begin
                cnt_q <= cnt_d;
                sat_q <= (cnt_d == CMAX);
            end
        end
    end

    assign det_o     = det_q;
    assign det_count = cnt_q;
    assign cnt_sat   = sat_q;
    assign fill      = fill_q;
endmodule
